// File: rtl/lzma_stream_framer.sv
// lzma_stream_framer
// Wraps each packet of the raw LZMA compressor byte stream into a complete
// .lzma container: a 13-byte header (properties, dictionary size, uncompressed
// size) followed by the payload, with full backpressure on both sides.
//
// Handshake rule, both ports: a byte moves on a rising clock edge where
// valid && ready are both high. The producer holds the byte and its side-band
// signals steady while valid is high and ready is low. Ready may depend
// combinationally on state but never on the same-side valid.

module lzma_stream_framer #(
  parameter logic [7:0]  LZMA_PROPS    = 8'h5E,
  parameter logic [31:0] DICT_SIZE     = 32'h0002_0000,
  parameter bit          SIZE_FIELD_EN = 1'b1,
  parameter int          CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rstn,
  // payload input (compressor side)
  input  logic             i_tvalid,
  output logic             i_tready,
  input  logic [7:0]       i_tdata,
  input  logic             i_tlast,
  // per-packet size information, sampled when a packet starts
  input  logic [63:0]      usize,
  input  logic             usize_known,
  // framed output (sink side)
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [7:0]       o_tdata,
  output logic             o_tlast,
  // statistics and status
  output logic [CNT_W-1:0] o_pkt_cnt,
  output logic [CNT_W-1:0] o_byte_cnt,
  output logic             o_busy,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic [3:0]       HDR_LAST_IDX = 4'd12;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e           state_q;
  logic [3:0]       hdr_idx_q;
  logic [63:0]      size_q;
  logic             o_tvalid_q;
  logic [7:0]       o_tdata_q;
  logic             o_tlast_q;
  logic [CNT_W-1:0] pkt_cnt_q;
  logic [CNT_W-1:0] byte_cnt_q;

  // Output stage can take a new byte when empty or being drained this cycle.
  logic             out_free;
  logic             out_fire;
  logic             in_fire;
  logic [103:0]     hdr_vec;
  logic [7:0]       hdr_byte;

  assign out_free = !o_tvalid_q || o_tready;
  assign out_fire = o_tvalid_q && o_tready;
  assign i_tready = (state_q == S_DATA) && out_free;
  assign in_fire  = i_tready && i_tvalid;

  // Header bytes laid out in emission order, byte k at bits [8k +: 8].
  assign hdr_vec  = {size_q, DICT_SIZE, LZMA_PROPS};

  // Select the header byte for the current header index.
  always_comb begin
    hdr_byte = 8'h00;
    if (hdr_idx_q <= HDR_LAST_IDX) begin
      hdr_byte = hdr_vec[{hdr_idx_q, 3'b000} +: 8];
    end
  end

  // Framing FSM with the one-entry output register and statistics counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      hdr_idx_q  <= 4'd0;
      size_q     <= '1;
      o_tvalid_q <= 1'b0;
      o_tdata_q  <= 8'h00;
      o_tlast_q  <= 1'b0;
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      if (out_fire) begin
        byte_cnt_q <= byte_cnt_q + CNT_ONE;
        // Drained; a load below in the same cycle overrides this.
        o_tvalid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          // The waiting payload byte stays upstream until the header is out.
          if (i_tvalid) begin
            state_q   <= S_HDR;
            hdr_idx_q <= 4'd0;
            if (SIZE_FIELD_EN && usize_known) begin
              size_q <= usize;
            end else begin
              size_q <= '1;
            end
          end
        end

        S_HDR: begin
          if (out_free) begin
            o_tvalid_q <= 1'b1;
            o_tdata_q  <= hdr_byte;
            o_tlast_q  <= 1'b0;
            if (hdr_idx_q == HDR_LAST_IDX) begin
              state_q   <= S_DATA;
              hdr_idx_q <= 4'd0;
            end else begin
              hdr_idx_q <= hdr_idx_q + 4'd1;
            end
          end
        end

        S_DATA: begin
          if (in_fire) begin
            o_tvalid_q <= 1'b1;
            o_tdata_q  <= i_tdata;
            o_tlast_q  <= i_tlast;
            if (i_tlast) begin
              state_q   <= S_IDLE;
              pkt_cnt_q <= pkt_cnt_q + CNT_ONE;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_tvalid    = o_tvalid_q;
  assign o_tdata     = o_tdata_q;
  assign o_tlast     = o_tlast_q;
  assign o_pkt_cnt   = pkt_cnt_q;
  assign o_byte_cnt  = byte_cnt_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_dbg_state = state_q;

endmodule
